// File: rtl/stage_fifo.sv
// Elastic multi-entry buffer between two pipeline stages.
// Valid/ready on both sides, synchronous flush, occupancy outputs.
module stage_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 2,
  parameter bit FULL_PASS = 1'b0,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             cpu_halt,
  input  logic             pipe_flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_rdy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_rdy,
  output logic [CW-1:0]    count_out,
  output logic             full_out,
  output logic             empty_out
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full, empty;
  logic             push, pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    // explicit wrap so non-power-of-2 depths work
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = ~empty & out_rdy;
  assign push  = in_valid & in_rdy;

  assign in_rdy = reset_in & ~cpu_halt
                & ~pipe_flush
                & (~full | (FULL_PASS & pop));

  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem_q[rd_q];
  assign count_out = cnt_q;
  assign full_out  = full;
  assign empty_out = empty;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (pipe_flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (pop)  rd_d = nxt(rd_q);
      if (push) wr_d = nxt(wr_q);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // payload storage needs no reset; it is masked while empty
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_q] <= in_data;
  end

endmodule

// File: tb/tb_stage_fifo.sv
// Randomised + directed bench for stage_fifo, two configurations
// sharing one stimulus stream, checked against queue models.
module tb_stage_fifo;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        cpu_halt;
  logic        pipe_flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_rdy;

  logic        rdy[2];
  logic        ov[2];
  logic [31:0] od[2];
  logic        fl[2];
  logic        em[2];
  logic [2:0]  cnt0;
  logic [1:0]  cnt1;
  logic [31:0] cnt[2];

  int n_checks = 0;
  int n_errors = 0;

  int dep[2] = '{4, 3};
  bit fp[2]  = '{1'b0, 1'b1};
  logic [31:0] mq[2][$];

  always #5 clk_in = ~clk_in;

  stage_fifo #(.WIDTH(32), .DEPTH(4), .FULL_PASS(1'b0)) u0 (
    .clk_in(clk_in), .reset_in(reset_in),
    .cpu_halt(cpu_halt), .pipe_flush(pipe_flush),
    .in_valid(in_valid), .in_data(in_data),
    .in_rdy(rdy[0]), .out_valid(ov[0]),
    .out_data(od[0]), .out_rdy(out_rdy),
    .count_out(cnt0), .full_out(fl[0]),
    .empty_out(em[0])
  );

  stage_fifo #(.WIDTH(32), .DEPTH(3), .FULL_PASS(1'b1)) u1 (
    .clk_in(clk_in), .reset_in(reset_in),
    .cpu_halt(cpu_halt), .pipe_flush(pipe_flush),
    .in_valid(in_valid), .in_data(in_data),
    .in_rdy(rdy[1]), .out_valid(ov[1]),
    .out_data(od[1]), .out_rdy(out_rdy),
    .count_out(cnt1), .full_out(fl[1]),
    .empty_out(em[1])
  );

  assign cnt[0] = 32'(cnt0);
  assign cnt[1] = 32'(cnt1);

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_rdy(input int k);
    int sz;
    bit pp;
    sz = mq[k].size();
    pp = (sz > 0) && out_rdy;
    return reset_in && !cpu_halt && !pipe_flush
        && ((sz < dep[k]) || (fp[k] && pp));
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int sz;
      sz = mq[k].size();
      chk($sformatf("u%0d.valid", k), 32'(ov[k]),
          32'(sz > 0));
      chk($sformatf("u%0d.data", k), od[k],
          (sz > 0) ? mq[k][0] : 32'h0);
      chk($sformatf("u%0d.count", k), cnt[k], 32'(sz));
      chk($sformatf("u%0d.full", k), 32'(fl[k]),
          32'(sz == dep[k]));
      chk($sformatf("u%0d.empty", k), 32'(em[k]),
          32'(sz == 0));
      chk($sformatf("u%0d.rdy", k), 32'(rdy[k]),
          32'(exp_rdy(k)));
    end
  endtask

  // inputs already driven at the falling edge
  task automatic cycle();
    bit pp[2];
    bit ps[2];
    #1;
    check_all();
    for (int k = 0; k < 2; k++) begin
      pp[k] = (mq[k].size() > 0) && out_rdy;
      ps[k] = in_valid && exp_rdy(k);
    end
    @(posedge clk_in);
    for (int k = 0; k < 2; k++) begin
      if (!reset_in || pipe_flush) begin
        mq[k].delete();
      end else begin
        if (pp[k]) void'(mq[k].pop_front());
        if (ps[k]) mq[k].push_back(in_data);
      end
    end
    @(negedge clk_in);
  endtask

  task automatic drive(
    input bit v, input logic [31:0] d,
    input bit r, input bit h, input bit f
  );
    in_valid   = v;
    in_data    = d;
    out_rdy    = r;
    cpu_halt   = h;
    pipe_flush = f;
    cycle();
  endtask

  task automatic idle_drain(input int n);
    for (int i = 0; i < n; i++) drive(0, 32'h0, 1, 0, 0);
  endtask

  initial begin
    reset_in   = 1'b0;
    cpu_halt   = 1'b0;
    pipe_flush = 1'b0;
    in_valid   = 1'b0;
    in_data    = 32'h0;
    out_rdy    = 1'b0;
    @(negedge clk_in);
    drive(1, 32'hDEAD, 1, 0, 0);
    reset_in = 1'b1;

    for (int i = 0; i < 4; i++)
      drive(1, 32'hA1 + 32'(i), 0, 0, 0);
    drive(1, 32'hA5, 0, 0, 0);
    idle_drain(5);

    for (int i = 1; i <= 3; i++)
      drive(1, 32'(i), 0, 0, 0);
    drive(1, 32'd4, 1, 0, 0);
    idle_drain(5);

    for (int i = 0; i < 20; i++)
      drive(1, 32'(i), 1, 0, 0);
    idle_drain(5);

    for (int i = 0; i < 3; i++)
      drive(1, 32'h10 + 32'(i), 0, 0, 0);
    drive(1, 32'h55, 0, 0, 1);
    drive(1, 32'h66, 0, 0, 0);
    idle_drain(3);

    for (int i = 0; i < 2; i++)
      drive(1, 32'h20 + 32'(i), 0, 0, 0);
    for (int i = 0; i < 3; i++)
      drive(1, 32'h99, 1, 1, 0);

    for (int i = 0; i < 3; i++)
      drive(1, 32'h30 + 32'(i), 0, 0, 0);
    #3;
    reset_in = 1'b0;
    mq[0].delete();
    mq[1].delete();
    #1;
    check_all();
    @(negedge clk_in);
    reset_in = 1'b1;
    drive(1, 32'h77, 0, 0, 0);
    idle_drain(3);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 24) == 0);
    end
    idle_drain(5);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stage_fifo.md
Name: stage_fifo

Overview:
- Parametrised, multi-entry elastic buffer placed between two CPU pipeline stages (e.g. Decode→Execute).
- Next generation of the single-entry stage register: configurable WIDTH/DEPTH, optional same-cycle pop/push when full, occupancy reporting, synchronous flush.
- Upstream and downstream use valid/rdy handshakes; an upstream stage drives the input side, the next stage drains the output side.

Parameters:
- WIDTH, 32, bits per entry (stage payload, ≥1).
- DEPTH, 2, number of entries (≥1, any integer, not restricted to power of 2).
- FULL_PASS, 0, 1 = when full, in_rdy is asserted if a pop occurs the same cycle; 0 = in_rdy strictly !full.

Ports:
- clk_in  input  1  clock, all state on rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- cpu_halt  input  1  1 = block new writes; the output side still drains.
- pipe_flush  input  1  1 = discard all entries at the next clock edge.
- in_valid  input  1  upstream has data.
- in_data  input  WIDTH  upstream payload.
- in_rdy  output  1  buffer accepts in_data this cycle.
- out_valid  output  1  head entry valid.
- out_data  output  WIDTH  head entry payload.
- out_rdy  input  1  downstream accepts head entry.
- count_out  output  $clog2(DEPTH+1)  number of occupied entries.
- full_out  output  1  count_out == DEPTH.
- empty_out  output  1  count_out == 0.

Behaviour:
- Reset (reset_in=0, async): count=0, read/write pointers=0, out_valid=0, full_out=0, empty_out=1, in_rdy=0, out_data='0. Storage contents are don't-care but must never be presented while out_valid=0.
- pop = out_valid & out_rdy. push = in_valid & in_rdy.
- in_rdy is combinational: reset_in & !cpu_halt & !pipe_flush & (!full_out | (FULL_PASS & pop)).
- Latency: data pushed at edge k appears on out_data with out_valid=1 after edge k when the buffer was empty. No combinational in→out bypass path.
- Ordering is strict FIFO. out_data = entry at the read pointer. out_valid = !empty_out.
- Pointers wrap from DEPTH-1 to 0; non-power-of-2 DEPTH is handled by explicit compare, not bit truncation.
- Count update at each edge:
  - push only: +1
  - pop only: -1
  - push and pop: unchanged, pointers both advance
  - neither: unchanged
- Push when full is allowed only when FULL_PASS=1 with a concurrent pop. Count stays DEPTH and the written slot is the one just vacated.
- Push and pop when count==1: the new entry becomes the head after the edge; out_valid stays 1.
- pipe_flush=1 at an edge:
  - count=0, pointers=0, out_valid=0 after the edge.
  - Flush overrides any concurrent push/pop; in_rdy is already 0.
  - A pop asserted in the flush cycle still counts as consumed by downstream (the data was visible). The flush does not re-present it.
- cpu_halt=1: in_rdy=0; pops continue normally; count can only fall.
- out_data/out_valid must be stable while out_valid=1 & out_rdy=0.
- Reset asserted mid-operation: all state clears immediately (async). The first push is accepted on the first edge after reset_in returns to 1.
- Pushing while in_rdy=0 is ignored (not an error).
- DEPTH=1 with FULL_PASS=0 gives single-register behaviour: the buffer accepts only every other cycle under continuous flow.

Test Plan:
- DEPTH=4, FULL_PASS=0: push 0xA1..0xA4 with out_rdy=0 → count 1,2,3,4. full_out=1 and in_rdy=0 after the 4th. Then out_rdy=1 → pops A1,A2,A3,A4 in order, empty_out=1 at end.
- DEPTH=3, FULL_PASS=1: fill with 1,2,3, then push 4 with out_rdy=1 → pop 1 and accept 4 in the same cycle, count stays 3. Draining yields 2,3,4 (exercises pointer wrap).
- DEPTH=4, continuous push+pop for 20 cycles (values 0..19) → out_data sequence 0..19, one cycle behind the input, count constant at 1.
- Load 3 entries, assert pipe_flush with in_valid=1 (data 0x55) → after the edge count=0, out_valid=0, 0x55 not stored. The next push of 0x66 is output first.
- Load 2 entries, hold cpu_halt=1 with in_valid=1, out_rdy=1 → in_rdy=0, both entries drained, count 2→1→0, no new data accepted.
- Drop reset_in low between edges with count=3 → immediately out_valid=0, count_out=0, empty_out=1. After release, a push of 0x77 appears as the head.
